// File: rtl/adding_datapath_if.sv
// Sequencer <-> adding datapath bus: control strobes,
// memory port and status returned to the sequencer.
interface adding_datapath_if;
  logic        rd_mem;
  logic        wr_mem;
  logic        ir_on_adr;
  logic        pc_on_adr;
  logic        ld_ir;
  logic        ld_ac;
  logic        ld_pc;
  logic        inc_pc;
  logic        clr_pc;
  logic        pass_add;
  logic [7:0]  mem_rdata;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  op_code;
  logic [7:0]  ac_out;
  logic        carry;
  logic        zero;
  logic [15:0] instr_cnt;

  modport master (
    output rd_mem, wr_mem, ir_on_adr, pc_on_adr,
    output ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
    output pass_add, mem_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  op_code, ac_out, carry, zero, instr_cnt
  );

  modport slave (
    input  rd_mem, wr_mem, ir_on_adr, pc_on_adr,
    input  ld_ir, ld_ac, ld_pc, inc_pc, clr_pc,
    input  pass_add, mem_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output op_code, ac_out, carry, zero, instr_cnt
  );
endinterface

// File: rtl/adding_datapath.sv
// Accumulator datapath: PC/IR/AC/carry registers, address
// mux and saturating instruction-fetch counter.
module adding_datapath (
  input logic               clk,
  input logic               reset,
  adding_datapath_if.slave  bus
);

  logic [5:0]  pc_q,  pc_d;
  logic [7:0]  ir_q,  ir_d;
  logic [7:0]  ac_q,  ac_d;
  logic        cy_q,  cy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  sum;

  assign sum = {1'b0, ac_q} + {3'b000, ir_q[5:0]};

  always_comb begin
    if (bus.pc_on_adr)
      bus.mem_addr = pc_q;
    else if (bus.ir_on_adr)
      bus.mem_addr = ir_q[5:0];
    else
      bus.mem_addr = 6'd0;
  end

  assign bus.mem_wdata = ac_q;
  assign bus.mem_re    = bus.rd_mem;
  assign bus.mem_we    = bus.wr_mem;
  assign bus.op_code   = ir_q[7:6];
  assign bus.ac_out    = ac_q;
  assign bus.carry     = cy_q;
  assign bus.zero      = (ac_q == 8'h00);
  assign bus.instr_cnt = cnt_q;

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    ac_d  = ac_q;
    cy_d  = cy_q;
    cnt_d = cnt_q;
    if (bus.ld_ir)
      ir_d = bus.mem_rdata;
    if (bus.clr_pc)
      pc_d = 6'd0;
    else if (bus.ld_pc)
      pc_d = ir_q[5:0];
    else if (bus.inc_pc)
      pc_d = pc_q + 6'd1;
    // a store must not disturb the value being written
    if (bus.ld_ac && !bus.wr_mem) begin
      if (bus.pass_add)
        {cy_d, ac_d} = sum;
      else
        ac_d = bus.mem_rdata;
    end
    if (bus.ld_ir && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= 6'd0;
      ir_q  <= 8'h00;
      ac_q  <= 8'h00;
      cy_q  <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      ac_q  <= ac_d;
      cy_q  <= cy_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/adding_datapath.md
ADDING_DATAPATH -- requirements
Module: adding_datapath

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have control inputs, 1 bit each, from the instruction sequencer: rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add.
REQ-004 SHALL have port: mem_rdata  input  8  asynchronous-read memory data, valid in the same cycle as mem_addr.
REQ-005 SHALL have port: mem_addr  output  6  memory address.
REQ-006 SHALL have port: mem_wdata  output  8  write data, always equal to AC.
REQ-007 SHALL have ports: mem_re  output  1  equal to rd_mem; mem_we  output  1  equal to wr_mem.
REQ-008 SHALL have port: op_code  output  2  equal to IR[7:6], returned to the sequencer.
REQ-009 SHALL have ports: ac_out  output  8  AC value; carry  output  1  carry flag; zero  output  1  high when AC==0.
REQ-010 SHALL have port: instr_cnt  output  16  count of instruction fetches.

Function
REQ-011 SHALL hold registers PC[5:0], IR[7:0], AC[7:0], CY, CNT[15:0]; all update only on rising clk.
REQ-012 SHALL drive mem_addr combinationally: PC if pc_on_adr; else IR[5:0] if ir_on_adr; else 6'd0; pc_on_adr wins when both are high.
REQ-013 SHALL load IR <= mem_rdata when ld_ir=1, else hold IR.
REQ-014 SHALL update PC with priority clr_pc > ld_pc > inc_pc: clear to 0; load IR[5:0]; increment modulo 64 (63 -> 0).
REQ-015 SHALL, when ld_ac=1, wr_mem=0 and pass_add=1, set {CY,AC} <= AC + {2'b00,IR[5:0]} as a 9-bit sum.
REQ-016 SHALL, when ld_ac=1, wr_mem=0 and pass_add=0, load AC <= mem_rdata and leave CY unchanged.
REQ-017 SHALL ignore ld_ac whenever wr_mem=1, so AC and CY hold and the store value is not corrupted.
REQ-018 SHALL hold AC and CY when ld_ac=0.
REQ-019 SHALL drive zero combinationally from AC (AC==8'h00).
REQ-020 SHALL increment CNT on every cycle with ld_ir=1, saturating at 16'hFFFF (no wrap).
REQ-021 SHALL apply all same-cycle register updates in parallel from pre-edge values; e.g. ld_ir with inc_pc loads IR from the old-PC address while PC increments.
REQ-022 SHALL place no combinational path from mem_rdata to any output.

Reset
REQ-023 SHALL, on reset=1 at a clk edge, set PC=0, IR=8'h00, AC=8'h00, CY=0, CNT=0, overriding all control inputs that cycle.
REQ-024 SHALL, after reset, output op_code=2'b00, ac_out=8'h00, carry=0, zero=1, instr_cnt=0, and mem_addr=0 when no address select is high.
REQ-025 SHALL abandon any in-flight operation on reset asserted mid-instruction; no partial AC, PC or IR update survives.

Verification
REQ-026 Fetch: PC=5, mem_rdata=8'h8A, pc_on_adr=rd_mem=ld_ir=inc_pc=1 -> mem_addr=5 that cycle; next cycle IR=8'h8A, op_code=2'b10, PC=6, instr_cnt incremented by 1.
REQ-027 Add with carry: AC=8'hF0, IR=8'h14, ld_ac=pass_add=1 -> AC=8'h04, CY=1, zero=0; AC=8'hEC, IR=8'h14 -> AC=8'h00, CY=1, zero=1.
REQ-028 Store vs. load: IR=8'h9F, AC=8'h3C, ir_on_adr=wr_mem=ld_ac=1, mem_rdata=8'hAA -> mem_addr=31, mem_we=1, mem_wdata=8'h3C, AC still 8'h3C next cycle; same stimulus with wr_mem=0, rd_mem=1 -> AC=8'hAA.
REQ-029 PC priority and wrap: PC=63, inc_pc=1 -> PC=0; IR=8'hE7, ld_pc=inc_pc=1 -> PC=39; clr_pc=ld_pc=1 -> PC=0.
REQ-030 Counter saturation: CNT preset near max via 65535 ld_ir cycles, then 3 more ld_ir cycles -> instr_cnt stays 16'hFFFF.
REQ-031 Reset mid-op: AC=8'h55, PC=12, reset=1 with ld_ac=inc_pc=1 -> next cycle AC=0, PC=0, IR=0, CY=0, CNT=0, zero=1.
